// File: rtl/md5_pkg.sv
// Shared constants and types for the md5 memory server: window geometry,
// the only legal access size, and the controller state encoding.
package md5_pkg;
  localparam logic [31:0] MSG_BASE_DEF = 32'h4000_0000;
  localparam logic [31:0] DIG_BASE_DEF = 32'h4000_0100;
  localparam int          MSG_WORDS    = 64;
  localparam int          DIG_WORDS    = 4;
  localparam logic [31:0] MSG_BYTES    = 32'd256;
  localparam logic [31:0] DIG_BYTES    = 32'd16;
  localparam logic [5:0]  WORD_SIZE    = 6'd32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_COOL = 2'd2
  } ctrl_state_t;
endpackage

// File: rtl/md5_mem_lane.sv
// One memory lane: decodes an access, flags protocol errors, and returns a
// registered acknowledge plus read data on the following cycle.
module md5_mem_lane
  import md5_pkg::*;
#(
  parameter logic [31:0] MSG_BASE = MSG_BASE_DEF,
  parameter logic [31:0] DIG_BASE = DIG_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        oe,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [5:0]  size,
  input  logic [31:0] msg_word,
  input  logic [31:0] dig_word,
  output logic [5:0]  msg_idx,
  output logic [1:0]  dig_idx,
  output logic        msg_wr,
  output logic        dig_wr,
  output logic        bad,
  output logic        rdy,
  output logic [31:0] rdata
);
  logic [31:0] msg_off;
  logic [31:0] dig_off;
  logic        in_msg;
  logic        in_dig;
  logic        ok;
  logic        en;
  logic [31:0] rdata_next;

  // Unsigned offsets wrap below the base, so one compare bounds both ends.
  assign msg_off = addr - MSG_BASE;
  assign dig_off = addr - DIG_BASE;
  assign in_msg  = msg_off < MSG_BYTES;
  assign in_dig  = dig_off < DIG_BYTES;
  assign msg_idx = msg_off[7:2];
  assign dig_idx = dig_off[3:2];

  assign en     = oe | we;
  assign ok     = (addr[1:0] == 2'b00) && (size == WORD_SIZE);
  assign msg_wr = we & ok & in_msg;
  assign dig_wr = we & ok & in_dig;
  assign bad    = en & (~ok | ~(in_msg | in_dig) | (oe & we));

  always_comb begin
    rdata_next = '0;
    if (oe && !we && ok) begin
      if (in_msg)      rdata_next = msg_word;
      else if (in_dig) rdata_next = dig_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy   <= 1'b0;
      rdata <= '0;
    end else begin
      rdy   <= en;
      rdata <= rdata_next;
    end
  end
endmodule

// File: rtl/md5_mem_server.sv
// Memory-mapped front end for an md5 core: message store, digest capture
// window, two independent access lanes and the start/cooldown controller.
module md5_mem_server
  import md5_pkg::*;
#(
  parameter logic [31:0] MSG_BASE = MSG_BASE_DEF,
  parameter logic [31:0] DIG_BASE = DIG_BASE_DEF,
  parameter int          COOLDOWN = 200
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         go,
  input  logic         load_valid,
  input  logic [5:0]   load_addr,
  input  logic [31:0]  load_data,
  output logic         start_port,
  input  logic         done_port,
  input  logic [1:0]   Mout_oe_ram,
  input  logic [1:0]   Mout_we_ram,
  input  logic [63:0]  Mout_addr_ram,
  input  logic [63:0]  Mout_Wdata_ram,
  input  logic [11:0]  Mout_data_ram_size,
  output logic [63:0]  M_Rdata_ram,
  output logic [1:0]   M_DataRdy,
  output logic [127:0] digest,
  output logic         digest_valid,
  output logic         busy,
  output logic         err
);
  localparam logic [31:0] COOL_LAST = 32'(COOLDOWN - 1);

  logic [31:0] msg_mem [MSG_WORDS];
  logic [31:0] dig_word_reg [DIG_WORDS];
  logic [3:0]  mask_reg;
  logic [3:0]  mask_set;
  logic        mask_full;
  logic        go_accept;
  ctrl_state_t state_reg;
  logic [31:0] cool_cnt_reg;

  logic [5:0]  msg_idx [2];
  logic [1:0]  dig_idx [2];
  logic [1:0]  msg_wr;
  logic [1:0]  dig_wr;
  logic [1:0]  lane_bad;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      md5_mem_lane #(
        .MSG_BASE(MSG_BASE),
        .DIG_BASE(DIG_BASE)
      ) u_lane (
        .clk     (clk),
        .rst_n   (rst_n),
        .oe      (Mout_oe_ram[gi]),
        .we      (Mout_we_ram[gi]),
        .addr    (Mout_addr_ram[32*gi +: 32]),
        .size    (Mout_data_ram_size[6*gi +: 6]),
        .msg_word(msg_mem[msg_idx[gi]]),
        .dig_word(dig_word_reg[dig_idx[gi]]),
        .msg_idx (msg_idx[gi]),
        .dig_idx (dig_idx[gi]),
        .msg_wr  (msg_wr[gi]),
        .dig_wr  (dig_wr[gi]),
        .bad     (lane_bad[gi]),
        .rdy     (M_DataRdy[gi]),
        .rdata   (M_Rdata_ram[32*gi +: 32])
      );
    end
  endgenerate

  assign go_accept = go && (state_reg == ST_IDLE);
  assign mask_full = (mask_reg == 4'hF);

  always_comb begin
    mask_set = '0;
    for (int l = 0; l < 2; l++) begin
      if (dig_wr[l]) mask_set[dig_idx[l]] = 1'b1;
    end
  end

  // Lane1 is applied last so it wins a same-word collision.
  always_ff @(posedge clk) begin
    if (load_valid && state_reg == ST_IDLE) msg_mem[load_addr] <= load_data;
    for (int l = 0; l < 2; l++) begin
      if (msg_wr[l]) msg_mem[msg_idx[l]] <= Mout_Wdata_ram[32*l +: 32];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DIG_WORDS; i++) dig_word_reg[i] <= '0;
      mask_reg     <= '0;
      digest       <= '0;
      digest_valid <= 1'b0;
    end else begin
      for (int l = 0; l < 2; l++) begin
        if (dig_wr[l]) dig_word_reg[dig_idx[l]] <= Mout_Wdata_ram[32*l +: 32];
      end
      digest_valid <= mask_full;
      if (mask_full) digest <= {dig_word_reg[3], dig_word_reg[2], dig_word_reg[1], dig_word_reg[0]};
      mask_reg <= ((mask_full || go_accept) ? 4'h0 : mask_reg) | mask_set;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      start_port   <= 1'b0;
      busy         <= 1'b0;
      cool_cnt_reg <= '0;
      err          <= 1'b0;
    end else begin
      if ((|lane_bad) || (load_valid && state_reg != ST_IDLE)) err <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (go) begin
            state_reg  <= ST_RUN;
            start_port <= 1'b1;
            busy       <= 1'b1;
          end
        end
        ST_RUN: begin
          if (done_port) begin
            state_reg    <= ST_COOL;
            start_port   <= 1'b0;
            cool_cnt_reg <= '0;
          end
        end
        ST_COOL: begin
          if (cool_cnt_reg == COOL_LAST) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else begin
            cool_cnt_reg <= cool_cnt_reg + 32'd1;
          end
        end
        default: begin
          state_reg  <= ST_IDLE;
          start_port <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_md5_mem_server.sv
// Randomised scoreboard bench for md5_mem_server; the bench itself plays the
// md5 core by writing the known digest into the capture window.
module tb_md5_mem_server;
  localparam logic [31:0]  MB    = 32'h4000_0000;
  localparam logic [31:0]  DB    = 32'h4000_0100;
  localparam logic [127:0] KNOWN = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4;

  logic         clk;
  logic         rst_n;
  logic         go;
  logic         load_valid;
  logic [5:0]   load_addr;
  logic [31:0]  load_data;
  logic         start_port;
  logic         done_port;
  logic [1:0]   Mout_oe_ram;
  logic [1:0]   Mout_we_ram;
  logic [63:0]  Mout_addr_ram;
  logic [63:0]  Mout_Wdata_ram;
  logic [11:0]  Mout_data_ram_size;
  logic [63:0]  M_Rdata_ram;
  logic [1:0]   M_DataRdy;
  logic [127:0] digest;
  logic         digest_valid;
  logic         busy;
  logic         err;

  md5_mem_server dut (
    .clk(clk), .rst_n(rst_n), .go(go),
    .load_valid(load_valid), .load_addr(load_addr), .load_data(load_data),
    .start_port(start_port), .done_port(done_port),
    .Mout_oe_ram(Mout_oe_ram), .Mout_we_ram(Mout_we_ram),
    .Mout_addr_ram(Mout_addr_ram), .Mout_Wdata_ram(Mout_Wdata_ram),
    .Mout_data_ram_size(Mout_data_ram_size),
    .M_Rdata_ram(M_Rdata_ram), .M_DataRdy(M_DataRdy),
    .digest(digest), .digest_valid(digest_valid),
    .busy(busy), .err(err)
  );

  typedef struct {
    int          due;
    logic [31:0] data;
  } ack_t;

  ack_t         q0[$];
  ack_t         q1[$];
  logic [127:0] dq[$];
  logic [31:0]  m_mem [64];
  logic [31:0]  m_dig [4];
  logic [3:0]   m_mask;
  logic         m_err;
  logic         m_busy;
  int           total = 0;
  int           bad = 0;
  int           cycle = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Monitor: pops one expectation per acknowledge / digest pulse.
  ack_t        mon_e;
  logic [31:0] mon_d;
  always @(negedge clk) begin
    if (rst_n) begin
      for (int l = 0; l < 2; l++) begin
        mon_d = M_Rdata_ram[32*l +: 32];
        if (l == 0 && q0.size() > 0 && q0[0].due < cycle) begin
          mon_e = q0.pop_front(); total++; bad++;
          $display("FAIL missing_ack lane0 due %0d now %0d", mon_e.due, cycle);
        end
        if (l == 1 && q1.size() > 0 && q1[0].due < cycle) begin
          mon_e = q1.pop_front(); total++; bad++;
          $display("FAIL missing_ack lane1 due %0d now %0d", mon_e.due, cycle);
        end
        if (M_DataRdy[l]) begin
          if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0)) begin
            total++; bad++;
            $display("FAIL unexpected_ack lane%0d cycle %0d data %0h", l, cycle, mon_d);
          end else begin
            mon_e = (l == 0) ? q0.pop_front() : q1.pop_front();
            chk($sformatf("ack_cycle_l%0d", l), 128'(cycle), 128'(mon_e.due));
            chk($sformatf("rdata_l%0d", l), {96'd0, mon_d}, {96'd0, mon_e.data});
          end
        end
      end
      if (digest_valid) begin
        if (dq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_digest_valid got %0h", digest);
        end else begin
          chk("digest_on_valid", digest, dq.pop_front());
        end
      end
    end
  end

  // One access cycle on both lanes; the model computes reads first so a
  // same-cycle write is not visible to them.
  task automatic acc(input logic [1:0] oe, input logic [1:0] we,
                     input logic [31:0] a0, input logic [31:0] a1,
                     input logic [31:0] d0, input logic [31:0] d1,
                     input logic [5:0] s0, input logic [5:0] s1);
    logic [31:0] a [2];
    logic [31:0] d [2];
    logic [5:0]  s [2];
    logic [31:0] rd;
    logic [31:0] om;
    logic [31:0] od;
    logic        ok;
    ack_t        e;
    a[0] = a0; a[1] = a1; d[0] = d0; d[1] = d1; s[0] = s0; s[1] = s1;
    Mout_oe_ram = oe; Mout_we_ram = we;
    Mout_addr_ram = {a1, a0}; Mout_Wdata_ram = {d1, d0};
    Mout_data_ram_size = {s1, s0};
    for (int l = 0; l < 2; l++) begin
      if (oe[l] || we[l]) begin
        om = a[l] - MB; od = a[l] - DB;
        ok = (a[l][1:0] == 2'b00) && (s[l] == 6'd32);
        rd = 32'd0;
        if (we[l]) begin
          if (!(ok && (om < 256 || od < 16)) || oe[l]) m_err = 1'b1;
        end else if (ok && om < 256) rd = m_mem[om >> 2];
        else if (ok && od < 16) rd = m_dig[od >> 2];
        else m_err = 1'b1;
        e.due = cycle + 1; e.data = rd;
        if (l == 0) q0.push_back(e); else q1.push_back(e);
      end
    end
    for (int l = 0; l < 2; l++) begin
      om = a[l] - MB; od = a[l] - DB;
      ok = (a[l][1:0] == 2'b00) && (s[l] == 6'd32);
      if (we[l] && ok && om < 256) m_mem[om >> 2] = d[l];
      else if (we[l] && ok && od < 16) begin
        m_dig[od >> 2] = d[l];
        m_mask[od >> 2] = 1'b1;
      end
    end
    if (m_mask == 4'hF) begin
      dq.push_back({m_dig[3], m_dig[2], m_dig[1], m_dig[0]});
      m_mask = 4'h0;
    end
    $display("acc cycle=%0d oe=%b we=%b a0=%h a1=%h d0=%h d1=%h s=%0d/%0d",
             cycle, oe, we, a0, a1, d0, d1, s0, s1);
    @(posedge clk); #1;
    Mout_oe_ram = 2'b00; Mout_we_ram = 2'b00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic load(input logic [5:0] addr, input logic [31:0] data);
    load_valid = 1'b1; load_addr = addr; load_data = data;
    if (m_busy) m_err = 1'b1; else m_mem[addr] = data;
    @(posedge clk); #1;
    load_valid = 1'b0;
  endtask

  task automatic do_go();
    go = 1'b1;
    if (!m_busy) begin m_mask = 4'h0; m_busy = 1'b1; end
    $display("go cycle=%0d", cycle);
    @(posedge clk); #1;
    go = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_start"}, 128'(start_port), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_err"}, 128'(err), 128'd0);
    chk({tag, "_rdy"}, 128'(M_DataRdy), 128'd0);
    chk({tag, "_rdata"}, 128'(M_Rdata_ram), 128'd0);
    chk({tag, "_digest"}, digest, 128'd0);
    chk({tag, "_dvalid"}, 128'(digest_valid), 128'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout at cycle %0d", cycle);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [1:0]  roe, rwe;
    logic [31:0] ra [2];
    logic [5:0]  rs [2];
    int          kind;
    rst_n = 1'b0; go = 1'b0; load_valid = 1'b0; load_addr = '0; load_data = '0;
    done_port = 1'b0; Mout_oe_ram = '0; Mout_we_ram = '0; Mout_addr_ram = '0;
    Mout_Wdata_ram = '0; Mout_data_ram_size = '0;
    m_mask = '0; m_err = 1'b0; m_busy = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 64; i++) load(6'(i), (i == 0) ? 32'h0000_0080 : 32'h0);
    acc(2'b01, 2'b00, MB, 32'h0, 32'h0, 32'h0, 6'd32, 6'd32);
    idle(3);
    acc(2'b00, 2'b11, DB + 4, DB + 4, 32'hAAAA_0000, 32'h5555_FFFF, 6'd32, 6'd32);
    acc(2'b01, 2'b00, DB + 4, 32'h0, 32'h0, 32'h0, 6'd32, 6'd32);
    acc(2'b11, 2'b00, MB + 4, MB, 32'h0, 32'h0, 6'd32, 6'd32);
    acc(2'b01, 2'b10, MB + 8, MB + 8, 32'h0, 32'h1234_5678, 6'd32, 6'd32);
    acc(2'b10, 2'b01, MB + 8, MB + 8, 32'h0, 32'h0, 6'd32, 6'd32);
    acc(2'b01, 2'b00, MB + 8, 32'h0, 32'h0, 32'h0, 6'd32, 6'd32);
    idle(3);
    chk("err_clean", 128'(err), 128'(m_err));

    do_go();
    chk("start_after_go", 128'(start_port), 128'd1);
    acc(2'b00, 2'b11, DB, DB + 4, KNOWN[31:0], KNOWN[63:32], 6'd32, 6'd32);
    acc(2'b00, 2'b11, DB + 8, DB + 12, KNOWN[95:64], KNOWN[127:96], 6'd32, 6'd32);
    idle(3);
    chk("digest_known", digest, KNOWN);
    done_port = 1'b1;
    @(posedge clk); #1;
    done_port = 1'b0;
    @(negedge clk);
    chk("start_drop", 128'(start_port), 128'd0);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      n++;
      go = (n == 100);
      @(negedge clk);
    end
    go = 1'b0;
    m_busy = 1'b0;
    chk("busy_cycles", 128'(n), 128'd200);
    repeat (3) begin
      @(negedge clk);
      chk("no_restart", 128'({start_port, busy}), 128'd0);
    end
    @(posedge clk); #1;
    done_port = 1'b1;
    @(posedge clk); #1;
    done_port = 1'b0;
    @(negedge clk);
    chk("done_idle_ign", 128'({start_port, busy}), 128'd0);
    @(posedge clk); #1;

    acc(2'b01, 2'b10, 32'h5000_0000, MB + 12, 32'h0, 32'h0000_FFFF, 6'd32, 6'd16);
    acc(2'b11, 2'b01, MB + 1, MB + 4, 32'h0, 32'h0, 6'd32, 6'd32);
    idle(3);
    chk("err_set", 128'(err), 128'd1);
    acc(2'b11, 2'b00, MB + 12, MB, 32'h0, 32'h0, 6'd32, 6'd32);
    idle(5);
    chk("err_sticky", 128'(err), 128'd1);

    do_go();
    load(6'd0, 32'hDEAD_BEEF);
    chk("start_run2", 128'(start_port), 128'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    m_err = 1'b0; m_mask = '0; m_busy = 1'b0;
    for (int i = 0; i < 4; i++) m_dig[i] = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_quiet", 128'({start_port, busy, M_DataRdy, digest_valid}), 128'd0);
    end
    @(posedge clk); #1;
    acc(2'b11, 2'b00, MB, DB, 32'h0, 32'h0, 6'd32, 6'd32);

    for (int t = 0; t < 300; t++) begin
      for (int l = 0; l < 2; l++) begin
        kind = $urandom_range(0, 9);
        case (kind)
          0, 1, 2, 3, 4: ra[l] = MB + 4 * $urandom_range(0, 63);
          5, 6:          ra[l] = DB + 4 * $urandom_range(0, 3);
          7:             ra[l] = 32'h5000_0000 + 4 * $urandom_range(0, 15);
          8:             ra[l] = MB + ($urandom_range(0, 255) | 1);
          default:       ra[l] = MB - 4;
        endcase
        rs[l] = ($urandom_range(0, 9) == 0) ? 6'd16 : 6'd32;
      end
      roe = 2'($urandom_range(0, 3));
      rwe = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
      acc(roe, rwe, ra[0], ra[1], $urandom, $urandom, rs[0], rs[1]);
    end
    idle(5);
    chk("err_final", 128'(err), 128'(m_err));
    chk("q0_drained", 128'(q0.size()), 128'd0);
    chk("q1_drained", 128'(q1.size()), 128'd0);
    chk("dq_drained", 128'(dq.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/md5_mem_server.md
MD5_MEM_SERVER -- requirements
Module: md5_mem_server

Interface
REQ-001 SHALL have parameter MSG_BASE, default 32'h40000000, base byte address of the 256-byte message window.
REQ-002 SHALL have parameter DIG_BASE, default 32'h40000100, base byte address of the 16-byte digest window.
REQ-003 SHALL have parameter COOLDOWN, default 200, idle cycles after done before the next start is allowed.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 go  in  1  request one hash run; sampled only in IDLE.
REQ-007 load_valid / load_addr / load_data  in  1 / 6 / 32  host write of one message word at word index load_addr.
REQ-008 start_port  out  1  start to the md5 core.
REQ-009 done_port  in  1  completion pulse from the md5 core.
REQ-010 Mout_oe_ram / Mout_we_ram  in  2 / 2  per-lane read/write enables; lane0 = bits [31:0], lane1 = bits [63:32].
REQ-011 Mout_addr_ram / Mout_Wdata_ram / Mout_data_ram_size  in  64 / 64 / 12  per-lane address, write data and access size in bits (6 bits per lane).
REQ-012 M_Rdata_ram / M_DataRdy  out  64 / 2  per-lane read data and per-lane access acknowledge.
REQ-013 digest / digest_valid  out  128 / 1  captured digest (word0 in [31:0]); one-cycle valid pulse.
REQ-014 busy / err  out  1 / 1  run in progress; sticky protocol-error flag.

Function
REQ-015 Message store: 64 x 32-bit words; byte address A maps to word (A-MSG_BASE)>>2.
REQ-016 Each lane is served independently; an access on cycle N (oe or we set) SHALL produce M_DataRdy[lane]=1 for exactly cycle N+1, with read data valid on the same cycle.
REQ-017 Reads inside the message window return the stored word; reads inside the digest window return the captured word; any other read returns 0 and sets err.
REQ-018 Writes inside the digest window store the word at index (A-DIG_BASE)>>2 and set that bit of a 4-bit capture mask; message-window writes update the store; other writes are discarded and set err.
REQ-019 Both lanes writing the same word in one cycle: lane1 data wins. A read and a write to the same word in one cycle: the read returns the old value.
REQ-020 Misaligned address (A[1:0]!=0) or size field !=32 on an enabled lane: access acknowledged, write discarded, read returns 0, err set.
REQ-021 oe and we both set on one lane: treated as a write, err set.
REQ-022 When the capture mask reaches 4'b1111, digest_valid SHALL pulse one cycle later and the mask SHALL clear.
REQ-023 Controller FSM: IDLE -> RUN on go; RUN holds start_port=1 until done_port=1, then -> COOL; COOL counts COOLDOWN cycles -> IDLE. busy=1 outside IDLE.
REQ-024 go in IDLE clears the capture mask; go outside IDLE is ignored.
REQ-025 load_valid in IDLE writes the message store; load_valid while busy is ignored and sets err.
REQ-026 done_port outside RUN is ignored.

Reset
REQ-027 Reset SHALL force FSM=IDLE, start_port=0, busy=0, err=0, M_DataRdy=0, M_Rdata_ram=0, digest=0, digest_valid=0, capture mask=0, cooldown counter=0; message store contents need not be reset.
REQ-028 Reset asserted mid-run SHALL abort it; no acknowledge and no digest_valid may appear after deassertion until new accesses occur.

Structure
REQ-029 Window bases, word counts, FSM state encoding and size constant 32 SHALL live in a shared package md5_pkg.
REQ-030 Per-lane decode/acknowledge SHALL be one sub-module md5_mem_lane, instantiated twice.

Verification
REQ-031 Load word0=32'h00000080 and words1..63=0, go, with the md5 core attached -> digest = 128'h7e42f8ec_980980e9_04b2008f_d98c1dd4 and one digest_valid pulse.
REQ-032 Lane0 read at 32'h40000000 on cycle N -> M_DataRdy=2'b01 and M_Rdata_ram[31:0]=32'h00000080 on N+1 only.
REQ-033 Both lanes write 32'h40000104 (lane0 32'hAAAA0000, lane1 32'h5555FFFF) -> the word reads back 32'h5555FFFF, mask bit1 set.
REQ-034 Read at 32'h50000000 and write with size 16 -> acknowledged next cycle, read data 0, err=1 and err stays 1 until reset.
REQ-035 done_port pulse during RUN -> start_port=0 next cycle, busy held 200 cycles, go on cooldown cycle 100 ignored.
REQ-036 Reset asserted while start_port=1 -> all outputs 0 immediately; FSM in IDLE after release.
